// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the LC-3b pipeline sequencer: fetch FSM states and pipe position indices.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_HOLD, I_DROP} pipe_istate_t;

  localparam int STG_PC = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;

endpackage

// File: rtl/pipe_ctrl_if.sv
// I-cache and D-cache handshake bundle between the pipeline sequencer (master) and the caches (slave).
interface pipe_ctrl_if #(parameter int IW = 16);
  logic          i_read;
  logic          i_resp;
  logic [IW-1:0] i_rdata;
  logic          d_mem_read;
  logic          d_mem_write;
  logic          d_resp;

  modport master (output i_read, d_mem_read, d_mem_write,
                  input  i_resp, i_rdata, d_resp);
  modport slave  (input  i_read, d_mem_read, d_mem_write,
                  output i_resp, i_rdata, d_resp);
endinterface

// File: rtl/pipe_ctrl_ifetch_buf.sv
// Fetch FSM plus instruction holding buffer: keeps a returned word until stage 1 can take it,
// and discards the in-flight response after a redirect.
module ifetch_buf
  import pipe_ctrl_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_resp,
  input  logic [IW-1:0] i_rdata,
  input  logic          accept,
  input  logic          flush,
  output logic          i_read,
  output logic [IW-1:0] ir_out,
  output logic          fetch_ok
);

  pipe_istate_t  state;
  logic [IW-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= I_IDLE;
      hold_q <= '0;
      i_read <= 1'b0;
    end else begin
      case (state)
        I_IDLE: begin
          state  <= I_WAIT;
          i_read <= 1'b1;
        end
        I_WAIT: begin
          // a response arriving with the redirect is simply dropped; only a
          // still-outstanding request needs the I_DROP detour
          if (flush) begin
            if (!i_resp) state <= I_DROP;
          end else if (i_resp && !accept) begin
            hold_q <= i_rdata;
            state  <= I_HOLD;
            i_read <= 1'b0;
          end
        end
        I_HOLD: begin
          if (flush || accept) begin
            state  <= I_WAIT;
            i_read <= 1'b1;
          end
        end
        I_DROP: begin
          if (i_resp) state <= I_WAIT;
        end
        default: begin
          state  <= I_IDLE;
          i_read <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_ok = ((state == I_WAIT) && i_resp) || (state == I_HOLD);
  assign ir_out   = (state == I_WAIT) ? i_rdata : hold_q;

endmodule

// File: rtl/pipe_ctrl.sv
// LC-3b pipeline sequencer: per-position valids, load enables, cache handshakes, bubbles and flush.
// Optional perf counters under `PIPE_PERF_CNT_EN; without it the counter ports read 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES      = 5,
  parameter int MEM_STAGE   = 3,
  parameter int REDIR_STAGE = 4,
  parameter int IW          = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_ctrl_if.master       mem,
  output logic [IW-1:0]     ir_out,
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic              hz_stall,
  input  logic              redirect,
  output logic [STAGES-1:0] stage_load,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_i_cnt,
  output logic [CNT_W-1:0]  stall_d_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [STAGES-1:0] valid_q, valid_d, load;
  logic              d_done, mem_req, d_stall;
  logic              fetch_ok, accept, flush;

  assign mem_req = valid_q[MEM_STAGE] & (d_req_read | d_req_write);
  assign d_stall = mem_req & ~mem.d_resp;
  assign accept  = fetch_ok & ~d_stall & ~hz_stall & ~redirect;
  assign flush   = redirect & ~d_stall;

  assign mem.d_mem_read  = ~reset & valid_q[MEM_STAGE] & d_req_read  & ~d_done;
  assign mem.d_mem_write = ~reset & valid_q[MEM_STAGE] & d_req_write & ~d_done;

  ifetch_buf #(.IW(IW)) u_ifetch (
    .clk      (clk),
    .reset    (reset),
    .i_resp   (mem.i_resp),
    .i_rdata  (mem.i_rdata),
    .accept   (accept),
    .flush    (flush),
    .i_read   (mem.i_read),
    .ir_out   (ir_out),
    .fetch_ok (fetch_ok)
  );

  // priority: d_stall > redirect > hz_stall > normal flow
  always_comb begin
    load            = '0;
    valid_d         = valid_q;
    valid_d[STG_PC] = 1'b1;
    if (d_stall) begin
      load = '0;
    end else if (redirect) begin
      load = '1;
      for (int k = 1; k < STAGES; k++)
        valid_d[k] = (k <= REDIR_STAGE) ? 1'b0 : valid_q[k-1];
    end else if (hz_stall) begin
      load         = '1;
      load[STG_PC] = 1'b0;
      load[STG_ID] = 1'b0;
      valid_d[STG_EX] = 1'b0;
      for (int k = STG_EX + 1; k < STAGES; k++)
        valid_d[k] = valid_q[k-1];
    end else begin
      load            = '1;
      load[STG_PC]    = accept;
      valid_d[STG_ID] = accept;
      for (int k = STG_EX; k < STAGES; k++)
        valid_d[k] = valid_q[k-1];
    end
    if (reset) load = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      d_done  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load[MEM_STAGE])
        d_done <= 1'b0;
      else if (mem_req && mem.d_resp)
        d_done <= 1'b1;
    end
  end

  assign stage_load  = load;
  assign stage_valid = valid_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] si_q, sd_q, fl_q;
  logic             i_starve;

  assign i_starve = ~accept & ~d_stall & ~redirect;

  // saturating: the increment is masked once a counter is all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      si_q <= '0;
      sd_q <= '0;
      fl_q <= '0;
    end else begin
      si_q <= si_q + CNT_W'(i_starve & ~&si_q);
      sd_q <= sd_q + CNT_W'(d_stall  & ~&sd_q);
      fl_q <= fl_q + CNT_W'(flush    & ~&fl_q);
    end
  end

  assign stall_i_cnt = si_q;
  assign stall_d_cnt = sd_q;
  assign flush_cnt   = fl_q;
`else
  assign stall_i_cnt = '0;
  assign stall_d_cnt = '0;
  assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: fill, D-cache stall, fetch hold, hazard bubble, redirect, reset mid-handshake.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir_out;
  logic        d_req_read, d_req_write, hz_stall, redirect;
  logic [4:0]  stage_load, stage_valid;
  logic [31:0] stall_i_cnt, stall_d_cnt, flush_cnt;
  logic [4:0]  exp_v;
  int          checks = 0;
  int          errors = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_ctrl_if #(.IW(16)) bus ();

  pipe_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (bus),
    .ir_out      (ir_out),
    .d_req_read  (d_req_read),
    .d_req_write (d_req_write),
    .hz_stall    (hz_stall),
    .redirect    (redirect),
    .stage_load  (stage_load),
    .stage_valid (stage_valid),
    .stall_i_cnt (stall_i_cnt),
    .stall_d_cnt (stall_d_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc(input int n);
    return PERF ? 32'(n) : 32'h0;
  endfunction

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic quiet;
    bus.i_resp = 1'b0; bus.i_rdata = 16'h0; bus.d_resp = 1'b0;
    d_req_read = 1'b0; d_req_write = 1'b0; hz_stall = 1'b0; redirect = 1'b0;
  endtask

  // ends in the first I_WAIT cycle with stage_valid = 00001
  task automatic do_reset;
    quiet();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    nxt();
  endtask

  task automatic fill4;
    for (int i = 0; i < 4; i++) begin
      bus.i_resp = 1'b1; bus.i_rdata = 16'(16'h4000 + i);
      nxt();
    end
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    nxt();
    smp();
    chk("rst_load",  32'(stage_load),      32'h0);
    chk("rst_valid", 32'(stage_valid),     32'h0);
    chk("rst_iread", 32'(bus.i_read),      32'h0);
    chk("rst_dmem",  32'({bus.d_mem_read, bus.d_mem_write}), 32'h0);
    chk("rst_ir",    32'(ir_out),          32'h0);
    nxt();
    reset = 1'b0;
    smp();
    chk("idle_iread", 32'(bus.i_read),   32'h0);
    chk("idle_valid", 32'(stage_valid),  32'h0);
    nxt();

    // fill with a response every cycle
    exp_v = 5'b00001;
    for (int i = 0; i < 8; i++) begin
      bus.i_resp = 1'b1; bus.i_rdata = 16'(16'h3000 + i);
      smp();
      chk("fill_load",  32'(stage_load),  32'h1f);
      chk("fill_valid", 32'(stage_valid), 32'(exp_v));
      chk("fill_ir",    32'(ir_out),      32'(16'h3000 + i));
      exp_v = {exp_v[3:0], 1'b1};
      nxt();
    end

    // load in MEM, response three cycles late
    bus.i_resp = 1'b0; d_req_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("dst_read",  32'(bus.d_mem_read), 32'h1);
      chk("dst_load",  32'(stage_load),     32'h0);
      chk("dst_valid", 32'(stage_valid),    32'h1f);
      nxt();
    end
    bus.d_resp = 1'b1;
    smp();
    chk("dresp_read", 32'(bus.d_mem_read), 32'h1);
    chk("dresp_load", 32'(stage_load),     32'h1e);
    nxt();
    bus.d_resp = 1'b0; d_req_read = 1'b0;
    smp();
    chk("dpost_read",  32'(bus.d_mem_read), 32'h0);
    chk("dpost_valid", 32'(stage_valid),    32'h1d);
    chk("dpost_sdcnt", stall_d_cnt,         pc(3));
    chk("dpost_sicnt", stall_i_cnt,         pc(2));
    nxt();

    // fetch response during D stall goes to the holding buffer
    d_req_read = 1'b1; bus.i_resp = 1'b1; bus.i_rdata = 16'h1234;
    smp();
    chk("hold_load0", 32'(stage_load),     32'h0);
    chk("hold_dread", 32'(bus.d_mem_read), 32'h1);
    nxt();
    bus.i_resp = 1'b0; bus.i_rdata = 16'hdead;
    smp();
    chk("hold_iread", 32'(bus.i_read),  32'h0);
    chk("hold_ir",    32'(ir_out),      32'h1234);
    chk("hold_load1", 32'(stage_load),  32'h0);
    nxt();
    bus.d_resp = 1'b1;
    smp();
    chk("hold_rel_load", 32'(stage_load), 32'h1f);
    chk("hold_rel_ir",   32'(ir_out),     32'h1234);
    nxt();
    bus.d_resp = 1'b0; d_req_read = 1'b0;
    smp();
    chk("hold_wait_iread", 32'(bus.i_read),  32'h1);
    chk("hold_wait_valid", 32'(stage_valid), 32'h13);
    chk("hold_sdcnt",      stall_d_cnt,      pc(5));
    nxt();

    // one-cycle hazard bubble at full pipe
    do_reset();
    fill4();
    bus.i_resp = 1'b1; bus.i_rdata = 16'h5a5a; hz_stall = 1'b1;
    smp();
    chk("hz_load",  32'(stage_load),  32'h1c);
    chk("hz_valid", 32'(stage_valid), 32'h1f);
    nxt();
    hz_stall = 1'b0; bus.i_resp = 1'b0; bus.i_rdata = 16'h0;
    smp();
    chk("hz_bubble", 32'(stage_valid), 32'h1b);
    chk("hz_iread",  32'(bus.i_read),  32'h0);
    chk("hz_ir",     32'(ir_out),      32'h5a5a);
    chk("hz_resume", 32'(stage_load),  32'h1f);
    nxt();

    // redirect with a fetch outstanding
    redirect = 1'b1;
    smp();
    chk("rd_load",  32'(stage_load),  32'h1f);
    chk("rd_valid", 32'(stage_valid), 32'h17);
    nxt();
    redirect = 1'b0; bus.i_resp = 1'b1; bus.i_rdata = 16'hbad0;
    smp();
    chk("drop_valid", 32'(stage_valid), 32'h01);
    chk("drop_iread", 32'(bus.i_read),  32'h1);
    chk("drop_load",  32'(stage_load),  32'h1e);
    nxt();
    bus.i_rdata = 16'h600d;
    smp();
    chk("refetch_valid", 32'(stage_valid), 32'h01);
    chk("refetch_load",  32'(stage_load),  32'h1f);
    chk("refetch_ir",    32'(ir_out),      32'h600d);
    nxt();
    bus.i_resp = 1'b0;
    smp();
    chk("refetch_in", 32'(stage_valid), 32'h03);
    chk("rd_flcnt",   flush_cnt,        pc(1));
    chk("rd_sicnt",   stall_i_cnt,      pc(3));
    nxt();

    // reset in the middle of a D handshake, late response afterwards
    do_reset();
    fill4();
    bus.i_resp = 1'b0; d_req_read = 1'b1;
    smp();
    chk("mid_dread", 32'(bus.d_mem_read), 32'h1);
    nxt();
    reset = 1'b1;
    smp();
    chk("mid_rst_dread", 32'(bus.d_mem_read), 32'h0);
    chk("mid_rst_load",  32'(stage_load),     32'h0);
    nxt();
    reset = 1'b0; bus.d_resp = 1'b1;
    smp();
    chk("late_dread", 32'(bus.d_mem_read), 32'h0);
    chk("late_valid", 32'(stage_valid),    32'h0);
    chk("late_sdcnt", stall_d_cnt,         32'h0);
    nxt();
    bus.d_resp = 1'b0; d_req_read = 1'b0;
    smp();
    chk("after_valid", 32'(stage_valid), 32'h01);
    chk("after_iread", 32'(bus.i_read),  32'h1);
    chk("after_sdcnt", stall_d_cnt,      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
